control_sequencer: RTL and testbench

- Hardwired control unit that drives the CPU datapath's control inputs; sits directly upstream of the datapath.
- Steps a one-state-per-clock fetch/execute sequence: T0..T2 fetch, T3..T6 execute.
- Decodes the IR value returned by the datapath and produces the register-enable, bus-select, memory and ALU-select strobes for register ALU ops, mul/div, nop and halt.

---
 rtl/control_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the CPU datapath.
// One state per clock; all strobes are a Moore decode of the state register and IR.
module control_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                Run,
    input  logic [31:0]         IR,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                Loin,
    output logic                HIin,
    output logic [4:0]          ALUSelection,
    output logic                Halted,
    output logic                Illegal,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b10001;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_rtype, is_muldiv, is_nop, is_halt, is_illegal;
    logic       retire;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    assign is_rtype   = ~opcode[4];
    assign is_muldiv  = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign is_nop     = (opcode == OP_NOP);
    assign is_halt    = (opcode == OP_HALT);
    assign is_illegal = ~is_rtype & ~is_muldiv & ~is_nop & ~is_halt;

    // Register index outside NUM_REGS selects nothing rather than aliasing.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [3:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            oh[i] = (int'(idx) == i);
        end
        return oh;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: if (Run) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_rtype || is_muldiv) state_d = S_T4;
                else if (is_halt)          state_d = S_HALT;
                else                       retire  = 1'b1;
            end
            S_T4:   state_d = S_T5;
            S_T5: begin
                if (is_muldiv) state_d = S_T6;
                else           retire  = 1'b1;
            end
            S_T6:   retire  = 1'b1;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (retire) begin
            state_d = Run ? S_T0 : S_IDLE;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        Rin          = '0;
        Rout         = '0;
        PCout        = 1'b0;
        PCin         = 1'b0;
        IncPC        = 1'b0;
        MARin        = 1'b0;
        MDRin        = 1'b0;
        MDRout       = 1'b0;
        Read         = 1'b0;
        IRin         = 1'b0;
        Yin          = 1'b0;
        Zin          = 1'b0;
        ZLOout       = 1'b0;
        ZHIout       = 1'b0;
        Loin         = 1'b0;
        HIin         = 1'b0;
        ALUSelection = 5'b0;
        Halted       = 1'b0;
        Illegal      = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                Read   = 1'b1;
                MDRin  = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_rtype) begin
                    Rout = reg_onehot(rb);
                    Yin  = 1'b1;
                end else if (is_muldiv) begin
                    Rout = reg_onehot(ra);
                    Yin  = 1'b1;
                end else if (is_illegal) begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                if (is_rtype || is_muldiv) begin
                    Rout         = is_rtype ? reg_onehot(rc) : reg_onehot(rb);
                    Zin          = 1'b1;
                    ALUSelection = opcode;
                end
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (is_muldiv) Loin = 1'b1;
                else           Rin  = reg_onehot(ra);
            end
            S_T6: begin
                ZHIout = 1'b1;
                HIin   = 1'b1;
            end
            S_HALT: Halted = 1'b1;
            default: ;
        endcase
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle pushes its expected
// outputs; a negedge monitor pops and compares them against the DUT.
module tb_control_sequencer;

    localparam int NR = 16;
    localparam int CW = 4;

    logic          clk, clr, Run;
    logic [31:0]   IR;
    logic [NR-1:0] Rin, Rout;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin;
    logic ZLOout, ZHIout, Loin, HIin, Halted, Illegal;
    logic [4:0]    ALUSelection;
    logic [CW-1:0] instr_count;

    control_sequencer #(.NUM_REGS(NR), .CNT_W(CW)) dut (
        .clk(clk), .clr(clr), .Run(Run), .IR(IR),
        .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .ZLOout(ZLOout), .ZHIout(ZHIout),
        .Loin(Loin), .HIin(HIin), .ALUSelection(ALUSelection),
        .Halted(Halted), .Illegal(Illegal), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [15:0] rin;
        logic [15:0] rout;
        logic pcout, pcin, incpc, marin, mdrin, mdrout, read, irin;
        logic yin, zin, zlo, zhi, loin, hiin;
        logic [4:0]  alu;
        logic        halted;
        logic        illegal;
        logic [3:0]  cnt;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
    } sb_t;

    localparam int PH_IDLE = 7;
    localparam int PH_HALT = 8;

    sb_t        sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [3:0] cnt_m = '0;

    initial begin
        clk = 1'b0;
        #10;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic obs_t obs_now();
        obs_t o;
        o = '{rin: Rin, rout: Rout, pcout: PCout, pcin: PCin, incpc: IncPC,
              marin: MARin, mdrin: MDRin, mdrout: MDRout, read: Read, irin: IRin,
              yin: Yin, zin: Zin, zlo: ZLOout, zhi: ZHIout, loin: Loin, hiin: HIin,
              alu: ALUSelection, halted: Halted, illegal: Illegal, cnt: instr_count};
        return o;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] idx);
        logic [15:0] one;
        one = 16'd1;
        return one << idx;
    endfunction

    // Expected outputs for one phase of the instruction held in ir.
    function automatic obs_t model(input int ph, input logic [31:0] ir);
        obs_t o;
        logic [4:0] op;
        logic rt, md, nop, hlt;
        o   = '0;
        op  = ir[31:27];
        rt  = (op < 5'd16);
        md  = (op == 5'd16) || (op == 5'd17);
        nop = (op == 5'd24);
        hlt = (op == 5'd25);
        case (ph)
            0: begin o.pcout = 1; o.marin = 1; o.incpc = 1; o.zin = 1; end
            1: begin o.zlo = 1; o.pcin = 1; o.read = 1; o.mdrin = 1; end
            2: begin o.mdrout = 1; o.irin = 1; end
            3: begin
                if (rt)      begin o.rout = oh(ir[22:19]); o.yin = 1; end
                else if (md) begin o.rout = oh(ir[26:23]); o.yin = 1; end
                else if (!nop && !hlt) o.illegal = 1;
            end
            4: begin
                o.rout = rt ? oh(ir[18:15]) : oh(ir[22:19]);
                o.zin  = 1;
                o.alu  = op;
            end
            5: begin
                o.zlo = 1;
                if (rt) o.rin = oh(ir[26:23]);
                else    o.loin = 1;
            end
            6: begin o.zhi = 1; o.hiin = 1; end
            PH_HALT: o.halted = 1;
            default: ;
        endcase
        return o;
    endfunction

    task automatic push_exp(input string tag, input int ph, input logic [31:0] ir);
        sb_t e;
        e.tag     = tag;
        e.exp     = model(ph, ir);
        e.exp.cnt = cnt_m;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in T0; returns in the instruction's final cycle.
    task automatic do_instr(input logic [31:0] ir, input logic run_end,
                            input int run_ph, input int abort_ph);
        int last;
        logic [4:0] op;
        op = ir[31:27];
        if (op < 5'd16)                        last = 5;
        else if (op == 5'd16 || op == 5'd17)   last = 6;
        else                                   last = 3;
        for (int p = 0; p <= last; p++) begin
            if (p > 0) next_cycle();
            if (p == 0) IR = ir;
            if (p == run_ph) Run = run_end;
            push_exp($sformatf("op%02h_T%0d", op, p), p, ir);
            if (p == abort_ph) begin
                @(negedge clk);
                #1;
                clr = 1'b1;
                #1;
                check_eq("clr_async", {7'b0, obs_now()}, 64'd0);
                cnt_m = '0;
                return;
            end
        end
        if (op != 5'd25) cnt_m = cnt_m + 1'b1;
    endtask

    function automatic logic [31:0] mk(input int op, input int ra, input int rb, input int rc);
        return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'b0};
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            sb_t e;
            e = sb.pop_front();
            check_eq(e.tag, {7'b0, obs_now()}, {7'b0, e.exp});
        end
    end

    initial begin
        clr = 1'b0;
        Run = 1'b0;
        IR  = 32'h0;
        #5;
        clr = 1'b1;
        #1;
        check_eq("reset_async", {7'b0, obs_now()}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        clr = 1'b0;

        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            if (i == 2) Run = 1'b1;
            push_exp("idle_run0", PH_IDLE, IR);
        end
        next_cycle();

        do_instr(32'h7B32_0000, 1'b1, 5, -1);
        next_cycle();
        do_instr(32'h8188_0000, 1'b1, 6, -1);
        next_cycle();
        do_instr(32'h8A50_0000, 1'b1, 6, -1);
        next_cycle();
        do_instr(32'h9000_0000, 1'b1, 3, -1);
        next_cycle();
        do_instr(mk(3, 0, 0, 0), 1'b1, 5, -1);
        next_cycle();

        // Run drops in T4; the instruction still completes, then IDLE.
        do_instr(mk(5, 2, 7, 7), 1'b0, 4, -1);
        next_cycle();
        push_exp("idle_after_drop", PH_IDLE, IR);
        next_cycle();
        Run = 1'b1;
        push_exp("idle_restart", PH_IDLE, IR);
        next_cycle();

        do_instr(mk(9, 15, 3, 12), 1'b1, 5, 4);
        @(posedge clk);
        #1;
        clr = 1'b0;
        push_exp("idle_after_clr", PH_IDLE, IR);
        next_cycle();

        for (int i = 0; i < 16; i++) begin
            do_instr(32'hC000_0000, 1'b1, 3, -1);
            next_cycle();
        end

        do_instr(32'hC800_0000, 1'b1, -1, -1);
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            push_exp("halted", PH_HALT, IR);
        end

        @(negedge clk);
        #1;
        check_eq("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
